// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: receive side of the 4-slot TDM link.
// Tracks frame alignment from the slot-0 sync marker and routes each word
// to its registered channel output with a per-channel valid strobe.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   HUNT   | no alignment; words are dropped until one arrives with sync
//   LOCKED | aligned; slot holds the index expected for the next word
//
// ALIGNED=0 updates each output as its word lands. ALIGNED=1 holds
// slots 0-2 in shadow registers and presents the whole frame together
// with the slot-3 word.
module tdm_demux_4ch #(
  parameter int WIDTH   = 8,
  parameter int ALIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] demux_in,
  input  logic             in_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] o_0,
  output logic [WIDTH-1:0] o_1,
  output logic [WIDTH-1:0] o_2,
  output logic [WIDTH-1:0] o_3,
  output logic [3:0]       o_valid,
  output logic             frame_done,
  output logic             sync_err,
  output logic             locked,
  output logic [1:0]       slot
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shadow_0;
  logic [WIDTH-1:0] shadow_1;
  logic [WIDTH-1:0] shadow_2;

  logic       cap_en;
  logic [1:0] cap_slot;
  logic       err;
  logic       lose_lock;

  assign locked = (state == LOCKED);

  // Classify the incoming word: capture (and as which slot), flag an
  // alignment error, or drop it and fall back to hunting.
  always_comb begin
    cap_en    = 1'b0;
    cap_slot  = slot;
    err       = 1'b0;
    lose_lock = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (frame_sync) begin
            cap_en   = 1'b1;
            cap_slot = 2'd0;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // A sync mid-frame restarts the frame at slot 0; the slots
            // already emitted for the partial frame are left as they are.
            cap_en   = 1'b1;
            cap_slot = 2'd0;
            err      = (slot != 2'd0);
          end else if (slot == 2'd0) begin
            err       = 1'b1;
            lose_lock = 1'b1;
          end else begin
            cap_en   = 1'b1;
            cap_slot = slot;
          end
        end
        default: begin
          lose_lock = 1'b1;
        end
      endcase
    end
  end

  // Alignment state, slot counter, channel registers and one-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      slot       <= 2'd0;
      o_0        <= '0;
      o_1        <= '0;
      o_2        <= '0;
      o_3        <= '0;
      shadow_0   <= '0;
      shadow_1   <= '0;
      shadow_2   <= '0;
      o_valid    <= 4'b0000;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      o_valid    <= 4'b0000;
      frame_done <= 1'b0;
      sync_err   <= err;

      if (lose_lock) begin
        state <= HUNT;
        slot  <= 2'd0;
      end

      if (cap_en) begin
        state <= LOCKED;
        slot  <= cap_slot + 2'd1;
        if (cap_slot == 2'd3) begin
          frame_done <= 1'b1;
        end

        if (ALIGNED != 0) begin
          // Shadows are overwritten before each slot 3, so a frame cut
          // short by an early sync never reaches the outputs.
          case (cap_slot)
            2'd0: shadow_0 <= demux_in;
            2'd1: shadow_1 <= demux_in;
            2'd2: shadow_2 <= demux_in;
            default: begin
              o_0     <= shadow_0;
              o_1     <= shadow_1;
              o_2     <= shadow_2;
              o_3     <= demux_in;
              o_valid <= 4'b1111;
            end
          endcase
        end else begin
          case (cap_slot)
            2'd0: begin
              o_0     <= demux_in;
              o_valid <= 4'b0001;
            end
            2'd1: begin
              o_1     <= demux_in;
              o_valid <= 4'b0010;
            end
            2'd2: begin
              o_2     <= demux_in;
              o_valid <= 4'b0100;
            end
            default: begin
              o_3     <= demux_in;
              o_valid <= 4'b1000;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch. Two instances share one stimulus
// stream: u_imm (ALIGNED=0) and u_aln (ALIGNED=1).
module tb_tdm_demux_4ch;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] demux_in;
  logic             in_valid;
  logic             frame_sync;

  logic [WIDTH-1:0] a_0, a_1, a_2, a_3;
  logic [3:0]       a_valid;
  logic             a_done, a_err, a_locked;
  logic [1:0]       a_slot;

  logic [WIDTH-1:0] b_0, b_1, b_2, b_3;
  logic [3:0]       b_valid;
  logic             b_done, b_err, b_locked;
  logic [1:0]       b_slot;

  int checks;
  int failures;

  tdm_demux_4ch #(.WIDTH(WIDTH), .ALIGNED(0)) u_imm (
    .clk(clk), .rst_n(rst_n), .demux_in(demux_in), .in_valid(in_valid),
    .frame_sync(frame_sync), .o_0(a_0), .o_1(a_1), .o_2(a_2), .o_3(a_3),
    .o_valid(a_valid), .frame_done(a_done), .sync_err(a_err),
    .locked(a_locked), .slot(a_slot)
  );

  tdm_demux_4ch #(.WIDTH(WIDTH), .ALIGNED(1)) u_aln (
    .clk(clk), .rst_n(rst_n), .demux_in(demux_in), .in_valid(in_valid),
    .frame_sync(frame_sync), .o_0(b_0), .o_1(b_1), .o_2(b_2), .o_3(b_3),
    .o_valid(b_valid), .frame_done(b_done), .sync_err(b_err),
    .locked(b_locked), .slot(b_slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one input cycle, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic s);
    in_valid   = v;
    demux_in   = d;
    frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b1;
    in_valid   = 1'b0;
    demux_in   = '0;
    frame_sync = 1'b0;

    // Asynchronous reset mid-cycle, before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_o0", a_0, 8'h00);
    chk("rst_o3", a_3, 8'h00);
    chk("rst_valid", a_valid, 4'b0000);
    chk("rst_locked", a_locked, 1'b0);
    chk("rst_slot", a_slot, 2'd0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_aln_valid", b_valid, 4'b0000);
    chk("rst_aln_o2", b_2, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);
    chk("idle_locked", a_locked, 1'b0);
    chk("idle_valid", a_valid, 4'b0000);
    chk("idle_aln_locked", b_locked, 1'b0);

    // HUNT drops words without sync, then locks on the sync word.
    step(1'b1, 8'h77, 1'b0);
    chk("hunt77_err", a_err, 1'b0);
    chk("hunt77_valid", a_valid, 4'b0000);
    chk("hunt77_locked", a_locked, 1'b0);
    step(1'b1, 8'h88, 1'b0);
    chk("hunt88_err", a_err, 1'b0);
    chk("hunt88_valid", a_valid, 4'b0000);
    step(1'b1, 8'h99, 1'b1);
    chk("lock99_valid", a_valid, 4'b0001);
    chk("lock99_o0", a_0, 8'h99);
    chk("lock99_o1", a_1, 8'h00);
    chk("lock99_locked", a_locked, 1'b1);
    chk("lock99_slot", a_slot, 2'd1);
    chk("lock99_err", a_err, 1'b0);
    chk("lock99_aln_valid", b_valid, 4'b0000);
    chk("lock99_aln_o0", b_0, 8'h00);
    chk("lock99_aln_locked", b_locked, 1'b1);

    step(1'b1, 8'hAA, 1'b0);
    chk("fa_valid1", a_valid, 4'b0010);
    step(1'b1, 8'hBB, 1'b0);
    chk("fa_valid2", a_valid, 4'b0100);
    chk("fa_slot2", a_slot, 2'd3);
    step(1'b1, 8'hCC, 1'b0);
    chk("fa_valid3", a_valid, 4'b1000);
    chk("fa_done", a_done, 1'b1);
    chk("fa_slot_wrap", a_slot, 2'd0);
    chk("fa_aln_valid", b_valid, 4'b1111);
    chk("fa_aln_done", b_done, 1'b1);
    chk("fa_aln_o0", b_0, 8'h99);
    chk("fa_aln_o3", b_3, 8'hCC);

    // Back-to-back frame, per-word strobes in the immediate variant.
    step(1'b1, 8'h11, 1'b1);
    chk("bb_v0", a_valid, 4'b0001);
    chk("bb_done0", a_done, 1'b0);
    chk("bb_aln_v0", b_valid, 4'b0000);
    step(1'b1, 8'h22, 1'b0);
    chk("bb_v1", a_valid, 4'b0010);
    chk("bb_aln_v1", b_valid, 4'b0000);
    step(1'b1, 8'h33, 1'b0);
    chk("bb_v2", a_valid, 4'b0100);
    chk("bb_aln_o2_hold", b_2, 8'hBB);
    step(1'b1, 8'h44, 1'b0);
    chk("bb_v3", a_valid, 4'b1000);
    chk("bb_done", a_done, 1'b1);
    chk("bb_o0", a_0, 8'h11);
    chk("bb_o1", a_1, 8'h22);
    chk("bb_o2", a_2, 8'h33);
    chk("bb_o3", a_3, 8'h44);
    chk("bb_aln_valid", b_valid, 4'b1111);
    chk("bb_aln_o1", b_1, 8'h22);
    step(1'b0, 8'h00, 1'b0);
    chk("bb_idle_valid", a_valid, 4'b0000);
    chk("bb_idle_done", a_done, 1'b0);
    chk("bb_idle_hold", a_2, 8'h33);

    // Gapped frame: aligned outputs appear together after the last word.
    step(1'b1, 8'hA0, 1'b1);
    chk("gap_a0_aln_valid", b_valid, 4'b0000);
    step(1'b0, 8'h00, 1'b1);
    chk("gap_idle_slot", b_slot, 2'd1);
    chk("gap_idle_aln_valid", b_valid, 4'b0000);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hA1, 1'b0);
    chk("gap_a1_imm_valid", a_valid, 4'b0010);
    chk("gap_a1_aln_valid", b_valid, 4'b0000);
    step(1'b1, 8'hA2, 1'b0);
    chk("gap_a2_aln_valid", b_valid, 4'b0000);
    step(1'b0, 8'h00, 1'b0);
    chk("gap_idle2_aln_done", b_done, 1'b0);
    step(1'b1, 8'hA3, 1'b0);
    chk("gap_aln_valid", b_valid, 4'b1111);
    chk("gap_aln_done", b_done, 1'b1);
    chk("gap_aln_o0", b_0, 8'hA0);
    chk("gap_aln_o1", b_1, 8'hA1);
    chk("gap_aln_o2", b_2, 8'hA2);
    chk("gap_aln_o3", b_3, 8'hA3);

    // Early sync on slot 2.
    step(1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h02, 1'b0);
    chk("es_pre_err", a_err, 1'b0);
    step(1'b1, 8'h03, 1'b1);
    chk("es_err", a_err, 1'b1);
    chk("es_o0", a_0, 8'h03);
    chk("es_valid", a_valid, 4'b0001);
    chk("es_slot", a_slot, 2'd1);
    chk("es_locked", a_locked, 1'b1);
    chk("es_aln_err", b_err, 1'b1);
    chk("es_aln_valid", b_valid, 4'b0000);
    chk("es_aln_done", b_done, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("es_err_once", a_err, 1'b0);
    step(1'b1, 8'h04, 1'b0);
    chk("es_o1", a_1, 8'h04);
    step(1'b1, 8'h05, 1'b0);
    chk("es_o2", a_2, 8'h05);
    step(1'b1, 8'h06, 1'b0);
    chk("es_o3", a_3, 8'h06);
    chk("es_done", a_done, 1'b1);
    chk("es_aln_valid_end", b_valid, 4'b1111);
    chk("es_aln_o0", b_0, 8'h03);
    chk("es_aln_o2", b_2, 8'h05);

    // Missing sync on slot 0.
    step(1'b1, 8'h55, 1'b0);
    chk("ms_err", a_err, 1'b1);
    chk("ms_locked", a_locked, 1'b0);
    chk("ms_slot", a_slot, 2'd0);
    chk("ms_valid", a_valid, 4'b0000);
    chk("ms_o0", a_0, 8'h03);
    chk("ms_aln_locked", b_locked, 1'b0);
    step(1'b1, 8'h66, 1'b0);
    chk("ms_hunt_err", a_err, 1'b0);
    chk("ms_hunt_valid", a_valid, 4'b0000);
    step(1'b0, 8'h00, 1'b1);
    chk("ms_sync_no_valid", a_locked, 1'b0);
    step(1'b1, 8'h12, 1'b1);
    chk("rl_locked", a_locked, 1'b1);
    chk("rl_o0", a_0, 8'h12);
    chk("rl_valid", a_valid, 4'b0001);

    // Reset in the middle of a frame.
    step(1'b1, 8'h13, 1'b0);
    chk("mr_o1", a_1, 8'h13);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mr_o1_clr", a_1, 8'h00);
    chk("mr_locked", a_locked, 1'b0);
    chk("mr_aln_o0", b_0, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    chk("mr_after_valid", a_valid, 4'b0000);
    chk("mr_after_slot", a_slot, 2'd0);
    step(1'b1, 8'h14, 1'b0);
    chk("mr_hunt_valid", a_valid, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
